stopwatch_core: RTL and testbench

Timekeeping and control core of the stopwatch. Consumes the 1 Hz divided clock from the clock divider as a sampled signal, debounces the start/stop and clear push-buttons, runs a CLEARED/RUNNING/PAUSED state machine, and drives the divider's `stop` input back from that state. Maintains an MM:SS BCD count for the display multiplexer. Fully synchronous to `clk_in`; the divided clock is never used as a clock.

---
 rtl/stopwatch_core.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: synchronizes the 1 Hz divider clock and two push-buttons,
// debounces the buttons, runs CLEARED/RUNNING/PAUSED control and keeps an MM:SS BCD count.
module stopwatch_core #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       stop,
  output logic       running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       rollover,
  output logic [1:0] state_dbg_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0] sec_sync_q, ss_sync_q, clr_sync_q;
  logic       sec_dly_q;
  logic [1:0] sync_valid_q;
  logic       tick;

  // Button index 0 is start/stop, index 1 is clear.
  logic [1:0]         btn_sync;
  logic [1:0]         stable_q, stable_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press_q, press_d;
  logic [1:0]         armed_q, armed_d;

  logic [3:0] sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d, min_tens_q, min_tens_d;
  logic       rollover_q, rollover_d;
  logic       stop_q, running_q;
  logic       clear_digits;

  assign btn_sync = {clr_sync_q[1], ss_sync_q[1]};
  assign tick     = sec_sync_q[1] & ~sec_dly_q;

  // A button is armed only once it has been seen released after reset, so a
  // button held through reset release cannot produce a press.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      stable_d[b] = stable_q[b];
      cnt_d[b]    = '0;
      press_d[b]  = 1'b0;
      armed_d[b]  = armed_q[b] | (sync_valid_q[1] & ~btn_sync[b] & ~stable_q[b]);
      if (btn_sync[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          stable_d[b] = btn_sync[b];
          press_d[b]  = btn_sync[b] & armed_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_digits = 1'b0;
    case (state_q)
      ST_CLEARED: if (press_q[0]) state_d = ST_RUNNING;
      ST_RUNNING: if (press_q[0]) state_d = ST_PAUSED;
      ST_PAUSED: begin
        if (press_q[1]) begin
          state_d      = ST_CLEARED;
          clear_digits = 1'b1;
        end else if (press_q[0]) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_CLEARED;
    endcase
  end

  // Increment qualifies on the current state, so a tick coinciding with the
  // press that leaves RUNNING is still counted.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    rollover_d = 1'b0;
    if (clear_digits) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if ((state_q == ST_RUNNING) && tick) begin
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (min_tens_q != 4'd5) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = 4'd0;
              rollover_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEARED;
      sec_sync_q   <= '0;
      ss_sync_q    <= '0;
      clr_sync_q   <= '0;
      sec_dly_q    <= 1'b0;
      sync_valid_q <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      press_q      <= '0;
      armed_q      <= '0;
      sec_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      min_tens_q   <= 4'd0;
      rollover_q   <= 1'b0;
      stop_q       <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_sync_q   <= {sec_sync_q[0], sec_clk};
      ss_sync_q    <= {ss_sync_q[0], btn_start_stop};
      clr_sync_q   <= {clr_sync_q[0], btn_clear};
      sec_dly_q    <= sec_sync_q[1];
      sync_valid_q <= {sync_valid_q[0], 1'b1};
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      armed_q      <= armed_d;
      sec_ones_q   <= sec_ones_d;
      sec_tens_q   <= sec_tens_d;
      min_ones_q   <= min_ones_d;
      min_tens_q   <= min_tens_d;
      rollover_q   <= rollover_d;
      stop_q       <= (state_d != ST_RUNNING);
      running_q    <= (state_d == ST_RUNNING);
    end
  end

  assign stop        = stop_q;
  assign running     = running_q;
  assign sec_ones    = sec_ones_q;
  assign sec_tens    = sec_tens_q;
  assign min_ones    = min_ones_q;
  assign min_tens    = min_tens_q;
  assign rollover    = rollover_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: elapsed-seconds reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_stopwatch_core;

  localparam int DB = 4;
  localparam int M_CLR = 0, M_RUN = 1, M_PAU = 2;

  // clock / reset
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  logic       sec_clk = 1'b0, btn_start_stop = 1'b0, btn_clear = 1'b0;
  logic       stop, running, rollover;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [1:0] state_dbg;
  logic [15:0] disp;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  stopwatch_core #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_in(clk_in), .reset(reset), .sec_clk(sec_clk),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .stop(stop), .running(running),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .rollover(rollover), .state_dbg_o(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [18:0] exp_q[$];

  // reference model: elapsed seconds as a plain integer
  int      m_secs = 0, m_state = M_CLR, m_age = 0;
  bit      m_roll = 1'b0;
  bit [3:0] h_sec = '0, h_ss = '0, h_clr = '0;
  bit      m_stable[2], m_armed[2], m_press[2];
  int      m_cnt[2];

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_state != M_RUN, m_state == M_RUN, m_roll, to_bcd(m_secs)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_state = M_CLR; m_roll = 1'b0; m_age = 0;
    h_sec = '0; h_ss = '0; h_clr = '0;
    for (int b = 0; b < 2; b++) begin
      m_stable[b] = 1'b0; m_armed[b] = 1'b0; m_press[b] = 1'b0; m_cnt[b] = 0;
    end
  endtask

  task automatic model_step();
    bit tick, ps, pc, y, arm_ok;
    bit np[2];
    h_sec = {h_sec[2:0], sec_clk};
    h_ss  = {h_ss[2:0], btn_start_stop};
    h_clr = {h_clr[2:0], btn_clear};
    m_age++;
    // a raw sample needs two edges to reach the logic
    tick = h_sec[2] & ~h_sec[3];
    ps = m_press[0];
    pc = m_press[1];
    m_roll = 1'b0;
    if (m_state == M_RUN && tick) begin
      if (m_secs == 3599) begin m_secs = 0; m_roll = 1'b1; end
      else m_secs++;
    end
    case (m_state)
      M_CLR: if (ps) m_state = M_RUN;
      M_RUN: if (ps) m_state = M_PAU;
      default: begin
        if (pc) begin m_state = M_CLR; m_secs = 0; end
        else if (ps) m_state = M_RUN;
      end
    endcase
    for (int b = 0; b < 2; b++) begin
      y = (b == 0) ? h_ss[2] : h_clr[2];
      np[b] = 1'b0;
      arm_ok = (m_age >= 3) && !y && !m_stable[b];
      if (y != m_stable[b]) begin
        m_cnt[b]++;
        if (m_cnt[b] == DB) begin
          m_stable[b] = y; m_cnt[b] = 0; np[b] = y && m_armed[b];
        end
      end else begin
        m_cnt[b] = 0;
      end
      if (arm_ok) m_armed[b] = 1'b1;
    end
    m_press = np;
  endtask

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
    exp_q.push_back(model_vec());
  end

  // scoreboard compare on the falling edge
  always @(negedge clk_in) begin
    if (chk_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({stop, running, rollover, disp} !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t got stop=%b run=%b roll=%b mmss=%h expected stop=%b run=%b roll=%b mmss=%h",
                   $time, stop, running, rollover, disp, e[18], e[17], e[16], e[15:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sec_pulse(input int hi, input int lo);
    sec_clk = 1'b1; edges(hi);
    sec_clk = 1'b0; edges(lo);
  endtask

  task automatic press(input logic ss, input logic clr);
    btn_start_stop = ss; btn_clear = clr;
    edges(6);
    btn_start_stop = 1'b0; btn_clear = 1'b0;
    edges(10);
  endtask

  initial begin
    edges(1);
    chk_en = 1'b1;
    edges(3);
    reset = 1'b0;
    edges(2);
    check_lit("reset_stop", 16'(stop), 16'd1);
    check_lit("reset_running", 16'(running), 16'd0);
    check_lit("reset_digits", disp, 16'h0000);
    check_lit("reset_rollover", 16'(rollover), 16'd0);

    // CLEARED ignores ticks and clear
    repeat (2) sec_pulse(10, 10);
    press(1'b0, 1'b1);
    check_lit("cleared_hold_digits", disp, 16'h0000);
    check_lit("cleared_hold_stop", 16'(stop), 16'd1);

    // start press: stop falls 2+4+1 edges later
    btn_start_stop = 1'b1;
    edges(6);
    check_lit("start_edge6_stop", 16'(stop), 16'd1);
    btn_start_stop = 1'b0;
    edges(1);
    check_lit("start_edge7_stop", 16'(stop), 16'd0);
    check_lit("start_edge7_running", 16'(running), 16'd1);
    edges(10);

    // each count lands 3 edges after the sec_clk rise
    for (int i = 0; i < 5; i++) begin
      sec_clk = 1'b1;
      edges(2);
      check_lit("tick_edge2", disp, 16'(i));
      edges(1);
      check_lit("tick_edge3", disp, 16'(i + 1));
      edges(7);
      sec_clk = 1'b0;
      edges(10);
    end
    check_lit("five_ticks", disp, 16'h0005);

    // bounce shorter than the debounce window is rejected
    for (int i = 0; i < 10; i++) begin
      btn_start_stop = ~btn_start_stop;
      edges(2);
    end
    edges(10);
    check_lit("bounce_no_change", 16'(running), 16'd1);
    btn_start_stop = 1'b1; edges(12);
    btn_start_stop = 1'b0; edges(10);
    check_lit("bounce_then_stable_run", 16'(running), 16'd0);
    check_lit("bounce_then_stable_stop", 16'(stop), 16'd1);
    check_lit("paused_digits", disp, 16'h0005);

    // resume and count to 03:27, then reset mid-cycle
    press(1'b1, 1'b0);
    repeat (202) sec_pulse(3, 3);
    check_lit("count_0327", disp, 16'h0327);
    #2 reset = 1'b1;
    #1;
    check_lit("async_reset_stop", 16'(stop), 16'd1);
    check_lit("async_reset_running", 16'(running), 16'd0);
    check_lit("async_reset_digits", disp, 16'h0000);
    edges(3);
    reset = 1'b0;
    edges(2);
    repeat (3) sec_pulse(10, 10);
    check_lit("post_reset_no_count", disp, 16'h0000);
    check_lit("post_reset_stop", 16'(stop), 16'd1);

    // preload to 59:58, then wrap
    press(1'b1, 1'b0);
    repeat (3598) sec_pulse(3, 3);
    check_lit("preload_5958", disp, 16'h5958);
    sec_pulse(10, 10);
    check_lit("count_5959", disp, 16'h5959);
    sec_clk = 1'b1;
    edges(2);
    check_lit("wrap_edge2_roll", 16'(rollover), 16'd0);
    edges(1);
    check_lit("wrap_digits", disp, 16'h0000);
    check_lit("wrap_roll_high", 16'(rollover), 16'd1);
    check_lit("wrap_running", 16'(running), 16'd1);
    edges(1);
    check_lit("wrap_roll_low", 16'(rollover), 16'd0);
    edges(6);
    sec_clk = 1'b0;
    edges(10);

    // clear is ignored while running
    repeat (12) sec_pulse(3, 3);
    press(1'b0, 1'b1);
    check_lit("run_clear_ignored", disp, 16'h0012);
    check_lit("run_clear_running", 16'(running), 16'd1);

    // pause press and tick act on the same edge
    btn_start_stop = 1'b1;
    edges(4);
    sec_clk = 1'b1;
    edges(2);
    btn_start_stop = 1'b0;
    edges(1);
    check_lit("pause_tick_digits", disp, 16'h0013);
    check_lit("pause_tick_stop", 16'(stop), 16'd1);
    check_lit("pause_tick_running", 16'(running), 16'd0);
    edges(7);
    sec_clk = 1'b0;
    edges(10);
    repeat (2) sec_pulse(10, 10);
    check_lit("paused_hold_0013", disp, 16'h0013);

    // simultaneous presses: clear wins in PAUSED, start wins in CLEARED
    press(1'b1, 1'b1);
    check_lit("both_paused_digits", disp, 16'h0000);
    check_lit("both_paused_stop", 16'(stop), 16'd1);
    check_lit("both_paused_running", 16'(running), 16'd0);
    press(1'b1, 1'b1);
    check_lit("both_cleared_stop", 16'(stop), 16'd0);
    check_lit("both_cleared_running", 16'(running), 16'd1);
    check_lit("both_cleared_digits", disp, 16'h0000);

    edges(5);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
